// File: rtl/fetch_prefetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_queue
//
// Instruction fetch front end. It owns the program counter, issues sequential
// word reads to the instruction RAM, and buffers the returned words with their
// PCs in a small FIFO. Decode sees the FIFO head and can stall. A redirect from
// a later stage flushes everything and restarts fetch at the new address.
//
// Parameters
//   DEPTH     FIFO entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset (word aligned)
//
// Ports
//   clk             rising-edge clock
//   reset_n         asynchronous active-low reset
//   rd_ram_en       read request strobe (at most one per cycle)
//   rd_ram_addr     word-aligned request address
//   rd_ram_data     read data, valid the cycle after the request
//   redirect_valid  flush and restart fetch at redirect_pc
//   redirect_pc     new fetch address, bits [1:0] ignored
//   stall           decode cannot accept this cycle
//   out_valid       out_inst/out_pc hold a valid instruction
//   out_inst        instruction word presented to decode
//   out_pc          address of out_inst
//
// Optional feature macro: PREFETCH_BYPASS_EN
//   When defined, a response that arrives while the FIFO is empty is shown
//   to decode in its arrival cycle; it only enters the FIFO if decode stalls.
// ---------------------------------------------------------------------------
module fetch_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        rd_ram_en,
    output logic [31:0] rd_ram_addr,
    input  logic [31:0] rd_ram_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);
    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_req_pc;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;
    logic          r_inflight;
    logic [31:0]   r_mem_inst [DEPTH];
    logic [31:0]   r_mem_pc   [DEPTH];

    logic          w_redirect;
    logic [31:0]   w_redirect_addr;
    logic [AW:0]   w_used;
    logic          w_issue;
    logic          w_resp;
    logic          w_fifo_nonempty;
    logic          w_bypass;
    logic          w_push;
    logic          w_pop;

    // Redirect is ignored while held in reset so the request port stays idle.
    assign w_redirect      = reset_n & redirect_valid;
    assign w_redirect_addr = {redirect_pc[31:2], 2'b00};

    // Credits come from registered state only: an entry popped this cycle
    // is not reusable until next cycle, which keeps the FIFO from overflowing.
    assign w_used          = r_count + {{AW{1'b0}}, r_inflight};
    assign w_issue         = reset_n & (w_redirect | (w_used < DEPTH_C));

    // The response of the old stream is dropped in a redirect cycle.
    assign w_resp          = r_inflight & ~w_redirect;
    assign w_fifo_nonempty = (r_count != '0);

`ifdef PREFETCH_BYPASS_EN
    assign w_bypass = w_resp & ~w_fifo_nonempty;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed response that decode accepts never needs a FIFO slot.
    assign w_push = w_resp & ~(w_bypass & ~stall);
    assign w_pop  = w_fifo_nonempty & ~stall;

    assign rd_ram_en   = w_issue;
    assign rd_ram_addr = w_redirect ? w_redirect_addr : r_fetch_pc;

    // Decode-facing outputs are zero whenever nothing valid is presented.
    always_comb begin
        out_valid = 1'b0;
        out_inst  = '0;
        out_pc    = '0;
        if (w_fifo_nonempty) begin
            out_valid = 1'b1;
            out_inst  = r_mem_inst[r_head];
            out_pc    = r_mem_pc[r_head];
        end else if (w_bypass) begin
            out_valid = 1'b1;
            out_inst  = rd_ram_data;
            out_pc    = r_req_pc;
        end
    end

    // Control state: pointers, occupancy, fetch PC and the outstanding request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
        end else if (w_redirect) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_inflight <= 1'b1;
            r_req_pc   <= w_redirect_addr;
            r_fetch_pc <= w_redirect_addr + 32'd4;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_req_pc   <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_push) begin
                r_tail <= r_tail + AW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read when r_count says valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_inst[r_tail] <= rd_ram_data;
            r_mem_pc[r_tail]   <= r_req_pc;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_prefetch_queue
//
// Drives fetch_prefetch_queue against a modelled instruction RAM whose data
// is (address ^ dataKey), and compares every cycle with a queue-based
// reference model of the fetch front end, plus scenario-specific checks.
// ---------------------------------------------------------------------------
module tb_fetch_prefetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef PREFETCH_BYPASS_EN
    localparam int          LAT      = 1;
`else
    localparam int          LAT      = 2;
`endif

    logic        clk           = 1'b0;
    logic        resetN        = 1'b0;
    logic        stall         = 1'b0;
    logic        redirectValid = 1'b0;
    logic [31:0] redirectPc    = 32'h0;
    logic [31:0] dataKey       = 32'h0;
    logic [31:0] ramQ          = 32'h0;
    logic        rdRamEn;
    logic [31:0] rdRamAddr;
    logic [31:0] rdRamData;
    logic        outValid;
    logic [31:0] outInst;
    logic [31:0] outPc;
    logic [97:0] obs;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    entry_t      mq[$];
    bit          mInflight = 1'b0;
    logic [31:0] mReqPc    = 32'h0;
    logic [31:0] mFetchPc  = RESET_PC;

    fetch_prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset_n        (resetN),
        .rd_ram_en      (rdRamEn),
        .rd_ram_addr    (rdRamAddr),
        .rd_ram_data    (rdRamData),
        .redirect_valid (redirectValid),
        .redirect_pc    (redirectPc),
        .stall          (stall),
        .out_valid      (outValid),
        .out_inst       (outInst),
        .out_pc         (outPc)
    );

    always #5 clk = ~clk;

    // Instruction RAM: answers the cycle after a request.
    always @(posedge clk) begin
        if (rdRamEn) ramQ <= rdRamAddr;
    end
    assign rdRamData = ramQ ^ dataKey;

    assign obs = {rdRamEn, rdRamAddr, outValid, outInst, outPc};

    // Expected {en, addr, valid, inst, pc} for the current cycle.
    function automatic logic [97:0] modelExpect();
        logic        en;
        logic [31:0] addr;
        logic        v;
        logic [31:0] inst;
        logic [31:0] pc;
        bit          resp;
        bit          byp;
        if (!resetN) return {1'b0, RESET_PC, 1'b0, 32'h0, 32'h0};
        en   = redirectValid || ((mq.size() + int'(mInflight)) < DEPTH);
        addr = redirectValid ? {redirectPc[31:2], 2'b00} : mFetchPc;
        resp = mInflight && !redirectValid;
        byp  = 1'b0;
`ifdef PREFETCH_BYPASS_EN
        byp  = resp && (mq.size() == 0);
`endif
        v    = 1'b0;
        inst = 32'h0;
        pc   = 32'h0;
        if (mq.size() != 0) begin
            v    = 1'b1;
            inst = mq[0].inst;
            pc   = mq[0].pc;
        end else if (byp) begin
            v    = 1'b1;
            inst = mReqPc ^ dataKey;
            pc   = mReqPc;
        end
        return {en, addr, v, inst, pc};
    endfunction

    // Advance the model across a clock edge using this cycle's inputs.
    task automatic modelAdvance();
        bit en;
        bit byp;
        bit resp;
        if (!resetN) begin
            mq.delete();
            mInflight = 1'b0;
            mReqPc    = 32'h0;
            mFetchPc  = RESET_PC;
            return;
        end
        if (redirectValid) begin
            mq.delete();
            mInflight = 1'b1;
            mReqPc    = {redirectPc[31:2], 2'b00};
            mFetchPc  = mReqPc + 32'd4;
            return;
        end
        en   = (mq.size() + int'(mInflight)) < DEPTH;
        resp = mInflight;
        byp  = 1'b0;
`ifdef PREFETCH_BYPASS_EN
        byp  = resp && (mq.size() == 0);
`endif
        if (mq.size() != 0 && !stall) void'(mq.pop_front());
        if (resp && !(byp && !stall)) mq.push_back('{inst: mReqPc ^ dataKey, pc: mReqPc});
        mInflight = en;
        if (en) begin
            mReqPc   = mFetchPc;
            mFetchPc = mFetchPc + 32'd4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelAdvance();
        #1;
    endtask

    // One reset cycle; returns just after the release so cycle 0 begins.
    task automatic doReset();
        resetN        = 1'b0;
        stall         = 1'b0;
        redirectValid = 1'b0;
        tick();
        resetN = 1'b1;
    endtask

    task automatic test_reset();
        logic [97:0] expVec;
        resetN = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            expVec = {1'b0, RESET_PC, 1'b0, 64'h0};
            total++;
            if (obs !== expVec) begin
                bad++;
                $display("[TB] FAIL reset_values cyc=%0d got=%h exp=%h", c, obs, expVec);
            end
            tick();
        end
        resetN = 1'b1;
    endtask

    task automatic test_stream();
        logic [97:0] expVec;
        dataKey = 32'h0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            expVec = modelExpect();
            total++;
            if (obs !== expVec) begin
                bad++;
                $display("[TB] FAIL stream_model cyc=%0d got=%h exp=%h", c, obs, expVec);
            end
            total++;
            if (rdRamEn !== 1'b1 || rdRamAddr !== 32'(4 * c)) begin
                bad++;
                $display("[TB] FAIL stream_addr cyc=%0d got en=%b addr=%h exp addr=%h", c, rdRamEn, rdRamAddr, 32'(4 * c));
            end
            if (c >= LAT) begin
                total++;
                if (outValid !== 1'b1 || outPc !== 32'(4 * (c - LAT)) || outInst !== 32'(4 * (c - LAT))) begin
                    bad++;
                    $display("[TB] FAIL stream_out cyc=%0d got v=%b pc=%h inst=%h exp pc=%h", c, outValid, outPc, outInst, 32'(4 * (c - LAT)));
                end
            end
            tick();
        end
    endtask

    task automatic test_stall_fill();
        logic [97:0] expVec;
        int          reqs;
        doReset();
        dataKey = 32'h0;
        stall   = 1'b1;
        reqs    = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            expVec = modelExpect();
            total++;
            if (obs !== expVec) begin
                bad++;
                $display("[TB] FAIL stall_model cyc=%0d got=%h exp=%h", c, obs, expVec);
            end
            if (rdRamEn === 1'b1) reqs++;
            if (c >= LAT) begin
                total++;
                if (outValid !== 1'b1 || outPc !== 32'h0) begin
                    bad++;
                    $display("[TB] FAIL stall_hold cyc=%0d got v=%b pc=%h exp pc=0", c, outValid, outPc);
                end
            end
            tick();
        end
        total++;
        if (reqs != DEPTH) begin
            bad++;
            $display("[TB] FAIL stall_reqs got=%0d exp=%0d", reqs, DEPTH);
        end
        stall = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            expVec = modelExpect();
            total++;
            if (obs !== expVec) begin
                bad++;
                $display("[TB] FAIL drain_model cyc=%0d got=%h exp=%h", k, obs, expVec);
            end
            total++;
            if (outValid !== 1'b1 || outPc !== 32'(4 * k)) begin
                bad++;
                $display("[TB] FAIL drain_pc cyc=%0d got v=%b pc=%h exp pc=%h", k, outValid, outPc, 32'(4 * k));
            end
            if (k == 1) begin
                total++;
                if (rdRamEn !== 1'b1 || rdRamAddr !== 32'd16) begin
                    bad++;
                    $display("[TB] FAIL resume_addr got en=%b addr=%h exp addr=00000010", rdRamEn, rdRamAddr);
                end
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        logic [97:0] expVec;
        bit          seen;
        doReset();
        dataKey = 32'h0F0F_0000;
        stall   = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            expVec = modelExpect();
            total++;
            if (obs !== expVec) begin
                bad++;
                $display("[TB] FAIL redir_fill_model cyc=%0d got=%h exp=%h", c, obs, expVec);
            end
            tick();
        end
        stall         = 1'b0;
        redirectValid = 1'b1;
        redirectPc    = 32'h0000_1002;
        @(negedge clk);
        expVec = modelExpect();
        total++;
        if (obs !== expVec) begin
            bad++;
            $display("[TB] FAIL redir_cycle_model got=%h exp=%h", obs, expVec);
        end
        total++;
        if (rdRamEn !== 1'b1 || rdRamAddr !== 32'h0000_1000) begin
            bad++;
            $display("[TB] FAIL redir_addr got en=%b addr=%h exp addr=00001000", rdRamEn, rdRamAddr);
        end
        tick();
        redirectValid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            @(negedge clk);
            expVec = modelExpect();
            total++;
            if (obs !== expVec) begin
                bad++;
                $display("[TB] FAIL redir_after_model cyc=%0d got=%h exp=%h", c, obs, expVec);
            end
`ifndef PREFETCH_BYPASS_EN
            if (c == 0) begin
                total++;
                if (outValid !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL redir_flush got v=%b exp v=0", outValid);
                end
            end
`endif
            if (outValid === 1'b1) begin
                seen = 1'b1;
                total++;
                if (outPc !== 32'h0000_1000 || outInst !== (32'h0000_1000 ^ dataKey)) begin
                    bad++;
                    $display("[TB] FAIL redir_first got pc=%h inst=%h exp pc=00001000", outPc, outInst);
                end
            end
            tick();
        end
        if (!seen) begin
            total++;
            bad++;
            $display("[TB] FAIL redir_timeout got no valid output exp pc=00001000");
        end
    endtask

    task automatic test_redirect_stall();
        logic [97:0] expVec;
        bit          seen;
        doReset();
        dataKey = 32'h0000_0000;
        stall   = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            expVec = modelExpect();
            total++;
            if (obs !== expVec) begin
                bad++;
                $display("[TB] FAIL rs_fill_model cyc=%0d got=%h exp=%h", c, obs, expVec);
            end
            tick();
        end
        redirectValid = 1'b1;
        redirectPc    = 32'h0000_2000;
        tick();
        redirectValid = 1'b0;
        stall         = 1'b0;
        seen          = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            expVec = modelExpect();
            total++;
            if (obs !== expVec) begin
                bad++;
                $display("[TB] FAIL rs_model cyc=%0d got=%h exp=%h", c, obs, expVec);
            end
`ifndef PREFETCH_BYPASS_EN
            if (c == 0) begin
                total++;
                if (outValid !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL rs_flush got v=%b exp v=0", outValid);
                end
            end
`endif
            if (outValid === 1'b1) begin
                total++;
                if ((!seen && outPc !== 32'h0000_2000) || outPc < 32'h0000_2000) begin
                    bad++;
                    $display("[TB] FAIL rs_stale cyc=%0d got pc=%h exp pc>=00002000 first=00002000", c, outPc);
                end
                seen = 1'b1;
            end
            tick();
        end
        if (!seen) begin
            total++;
            bad++;
            $display("[TB] FAIL rs_timeout got no valid output exp pc=00002000");
        end
    endtask

    task automatic test_wrap();
        logic [97:0] expVec;
        logic [31:0] wrapSeq [3];
        wrapSeq[0]    = 32'hFFFF_FFF8;
        wrapSeq[1]    = 32'hFFFF_FFFC;
        wrapSeq[2]    = 32'h0000_0000;
        stall         = 1'b0;
        redirectValid = 1'b1;
        redirectPc    = 32'hFFFF_FFF8;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            expVec = modelExpect();
            total++;
            if (obs !== expVec) begin
                bad++;
                $display("[TB] FAIL wrap_model cyc=%0d got=%h exp=%h", c, obs, expVec);
            end
            if (c < 3) begin
                total++;
                if (rdRamEn !== 1'b1 || rdRamAddr !== wrapSeq[c]) begin
                    bad++;
                    $display("[TB] FAIL wrap_addr cyc=%0d got en=%b addr=%h exp addr=%h", c, rdRamEn, rdRamAddr, wrapSeq[c]);
                end
            end
            tick();
            redirectValid = 1'b0;
        end
    endtask

    task automatic test_reset_midstream();
        logic [97:0] expVec;
        bit          seen;
        doReset();
        dataKey = 32'h3C3C_0000;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            expVec = modelExpect();
            total++;
            if (obs !== expVec) begin
                bad++;
                $display("[TB] FAIL mid_pre_model cyc=%0d got=%h exp=%h", c, obs, expVec);
            end
            tick();
        end
        resetN = 1'b0;
        #1;
        total++;
        if (outValid !== 1'b0 || rdRamEn !== 1'b0 || rdRamAddr !== RESET_PC) begin
            bad++;
            $display("[TB] FAIL mid_async got v=%b en=%b addr=%h exp v=0 en=0 addr=%h", outValid, rdRamEn, rdRamAddr, RESET_PC);
        end
        tick();
        resetN = 1'b1;
        seen   = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            @(negedge clk);
            expVec = modelExpect();
            total++;
            if (obs !== expVec) begin
                bad++;
                $display("[TB] FAIL mid_post_model cyc=%0d got=%h exp=%h", c, obs, expVec);
            end
            if (outValid === 1'b1) begin
                seen = 1'b1;
                total++;
                if (outPc !== RESET_PC) begin
                    bad++;
                    $display("[TB] FAIL mid_first got pc=%h exp pc=%h", outPc, RESET_PC);
                end
            end
            tick();
        end
        if (!seen) begin
            total++;
            bad++;
            $display("[TB] FAIL mid_timeout got no valid output exp pc=%h", RESET_PC);
        end
    endtask

    task automatic test_random();
        logic [97:0] expVec;
        doReset();
        dataKey = $urandom;
        for (int c = 0; c < 600; c++) begin
            resetN        = ($urandom_range(0, 99) >= 2);
            stall         = ($urandom_range(0, 99) < 40);
            redirectValid = ($urandom_range(0, 99) < 7);
            if ($urandom_range(0, 3) == 0)
                redirectPc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else
                redirectPc = $urandom;
            @(negedge clk);
            expVec = modelExpect();
            total++;
            if (obs !== expVec) begin
                bad++;
                $display("[TB] FAIL random_model cyc=%0d got=%h exp=%h", c, obs, expVec);
            end
            tick();
        end
        resetN        = 1'b1;
        redirectValid = 1'b0;
        stall         = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_fill();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
